// File: rtl/dest_reg_pipe_if.sv
// Bundles the decode-side inputs and the pipeline/forwarding outputs of dest_reg_pipe.
// fwd_count exists only when DEST_REG_PIPE_STATS_EN is defined.
interface dest_reg_pipe_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] rt_in;
  logic [REG_ADDR_W-1:0] rd_in;
  logic [1:0]            regdst;
  logic                  regwrite_in;
  logic                  valid_in;
  logic                  stall;
  logic                  flush;
  logic [REG_ADDR_W-1:0] src_a;
  logic [REG_ADDR_W-1:0] src_b;
  logic [REG_ADDR_W-1:0] dest_out;
  logic                  regwrite_out;
  logic [2:0]            fwd_a_sel;
  logic [2:0]            fwd_b_sel;
`ifdef DEST_REG_PIPE_STATS_EN
  logic [15:0]           fwd_count;
`endif

  modport master (
    output rt_in, rd_in, regdst, regwrite_in, valid_in, stall, flush, src_a, src_b,
`ifdef DEST_REG_PIPE_STATS_EN
    input  fwd_count,
`endif
    input  dest_out, regwrite_out, fwd_a_sel, fwd_b_sel
  );

  modport slave (
    input  rt_in, rd_in, regdst, regwrite_in, valid_in, stall, flush, src_a, src_b,
`ifdef DEST_REG_PIPE_STATS_EN
    output fwd_count,
`endif
    output dest_out, regwrite_out, fwd_a_sel, fwd_b_sel
  );
endinterface

// File: rtl/dest_reg_pipe.sv
// Destination-register select plus a STAGES-deep dest/regwrite pipeline with stall, flush
// and youngest-match forwarding lookup. Define DEST_REG_PIPE_STATS_EN to add fwd_count.
module dest_reg_pipe #(
  parameter int REG_ADDR_W = 5,
  parameter int STAGES     = 3,
  parameter int LINK_REG   = 31
) (
  input logic            clk,
  input logic            reset,
  dest_reg_pipe_if.slave bus
);

  localparam logic [REG_ADDR_W-1:0] LinkAddr = REG_ADDR_W'(LINK_REG);

  logic [STAGES-1:0]     validQ, validD;
  logic [STAGES-1:0]     weQ, weD;
  logic [REG_ADDR_W-1:0] destQ [STAGES];
  logic [REG_ADDR_W-1:0] destD [STAGES];

  logic [REG_ADDR_W-1:0] selDest;
  logic                  selWe;
  logic [2:0]            fwdA, fwdB;

  // Reserved encoding yields address 0, so the $zero check also clears its write enable.
  always_comb begin
    selDest = '0;
    case (bus.regdst)
      2'b00:   selDest = bus.rt_in;
      2'b01:   selDest = bus.rd_in;
      2'b10:   selDest = LinkAddr;
      default: selDest = '0;
    endcase
    selWe = bus.regwrite_in & bus.valid_in & (selDest != '0);
  end

  always_comb begin
    validD = validQ;
    weD    = weQ;
    destD  = destQ;
    if (bus.flush) begin
      validD[0] = 1'b0;
      weD[0]    = 1'b0;
      destD[0]  = '0;
    end else if (!bus.stall) begin
      validD[0] = bus.valid_in;
      weD[0]    = selWe;
      destD[0]  = selDest;
    end
    // A stall without flush leaves a bubble behind the held stage 0.
    for (int i = 1; i < STAGES; i++) begin
      if (i == 1 && bus.stall && !bus.flush) begin
        validD[i] = 1'b0;
        weD[i]    = 1'b0;
        destD[i]  = '0;
      end else begin
        validD[i] = validQ[i-1];
        weD[i]    = weQ[i-1];
        destD[i]  = destQ[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      validQ <= '0;
      weQ    <= '0;
      destQ  <= '{default: '0};
    end else begin
      validQ <= validD;
      weQ    <= weD;
      destQ  <= destD;
    end
  end

  // Scan oldest to youngest so the lowest matching stage is the one left standing.
  always_comb begin
    fwdA = '0;
    fwdB = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (validQ[i] && weQ[i] && (destQ[i] == bus.src_a) && (bus.src_a != '0))
        fwdA = 3'(i + 1);
      if (validQ[i] && weQ[i] && (destQ[i] == bus.src_b) && (bus.src_b != '0))
        fwdB = 3'(i + 1);
    end
  end

  assign bus.dest_out     = destQ[STAGES-1];
  assign bus.regwrite_out = weQ[STAGES-1];
  assign bus.fwd_a_sel    = fwdA;
  assign bus.fwd_b_sel    = fwdB;

`ifdef DEST_REG_PIPE_STATS_EN
  logic [15:0] fwdCountQ, fwdCountD;

  always_comb begin
    fwdCountD = fwdCountQ;
    if (((fwdA != '0) || (fwdB != '0)) && (fwdCountQ != 16'hFFFF))
      fwdCountD = fwdCountQ + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) fwdCountQ <= '0;
    else       fwdCountQ <= fwdCountD;
  end

  assign bus.fwd_count = fwdCountQ;
`endif

endmodule

// File: doc/dest_reg_pipe.md
Name: dest_reg_pipe

Overview:
- Parametrised successor to the single-cycle rt/rd destination select.
- Selects the write-back register address from one of three sources: rt, rd or the link register for jal/jalr-style writes.
- Carries the selected address and its regwrite flag through a STAGES-deep pipeline (EX/MEM/WB), with stall and flush control.
- Compares two source addresses against all in-flight destinations and reports the youngest match, for the forwarding unit.

Parameters:
- REG_ADDR_W, 5, register address width in bits.
- STAGES, 3, number of pipeline stages tracked; legal range 1..7.
- LINK_REG, 31, register address written when link mode is selected.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- rt_in  input  REG_ADDR_W  rt field of the decoding instruction.
- rd_in  input  REG_ADDR_W  rd field of the decoding instruction.
- regdst  input  2  destination select: 00 rt, 01 rd, 10 LINK_REG, 11 reserved.
- regwrite_in  input  1  decoding instruction writes the register file.
- valid_in  input  1  decoding slot holds a real instruction.
- stall  input  1  hold stage 0 and insert a bubble behind it.
- flush  input  1  kill the entry entering stage 0.
- src_a  input  REG_ADDR_W  rs of the instruction in decode.
- src_b  input  REG_ADDR_W  rt of the instruction in decode.
- dest_out  output  REG_ADDR_W  destination held in the last stage.
- regwrite_out  output  1  write enable of the last stage.
- fwd_a_sel  output  3  0 = no match; k = match in stage k-1 (youngest wins).
- fwd_b_sel  output  3  same encoding as fwd_a_sel, for src_b.

Behaviour:
- Entry per stage i (0..STAGES-1): valid[i], we[i], dest[i].
- Select (combinational, into stage 0):
  - 00 -> rt_in; 01 -> rd_in; 10 -> LINK_REG.
  - 11 -> address 0 with we forced to 0; the entry still advances as valid.
- Effective write enable: we = regwrite_in & valid_in & (selected dest != 0). Writes to $zero never propagate.
- Reset: all valid/we/dest cleared to 0 next edge. Outputs after reset: dest_out=0, regwrite_out=0, fwd_a_sel=0, fwd_b_sel=0.
- Reset mid-operation discards every in-flight entry; no partial retention.
- Normal cycle (no stall, no flush):
  - stage0 <- new selected entry.
  - stage i <- stage i-1 for i >= 1.
- stall=1, flush=0:
  - stage0 holds its value.
  - stage1 <- bubble (valid=0, we=0, dest=0).
  - stages >= 2 advance normally.
- flush=1 (regardless of stall):
  - stage0 <- bubble.
  - stage1 <- old stage0.
  - the rest advance. Flush takes priority over stall.
- With STAGES=1, stall simply holds stage0 and no bubble is inserted.
- Latency: a selected destination reaches dest_out STAGES edges after capture, plus one edge per stall cycle while it sits in stage0.
- dest_out and regwrite_out are driven directly from the last-stage register; no combinational path from inputs.
- Forwarding match, combinational from the registered state plus src_a/src_b:
  - Stage i matches src when valid[i] & we[i] & (dest[i] == src) & (src != 0).
  - fwd_x_sel = (lowest matching i) + 1, else 0.
  - fwd_a_sel and fwd_b_sel are evaluated independently and may both be nonzero.

Optional Feature:
DEST_REG_PIPE_STATS_EN
- Defined:
  - Adds output fwd_count (16 bits): count of cycles in which fwd_a_sel != 0 or fwd_b_sel != 0.
  - Saturates at 16'hFFFF; cleared by reset.
  - Does not count during cycles where reset is high.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: hold reset 2 cycles, release with valid_in=0 -> dest_out=0, regwrite_out=0 and both fwd_sel=0 for 5 cycles.
- Select and latency: cycle 0 regdst=00 rt=7 rd=9 regwrite=1 valid=1; cycle 1 regdst=01 rt=3 rd=12; cycle 2 regdst=10 -> with STAGES=3, dest_out/regwrite_out read 7/1, 12/1, 31/1 on edges 3, 4, 5.
- Zero and reserved: regdst=00 rt=0 regwrite=1; then regdst=11 rd=5 regwrite=1 -> both arrive with regwrite_out=0, and src_a=0 never produces fwd_a_sel != 0.
- Forwarding priority: stage0 dest=8 we=1, stage2 dest=8 we=1, src_a=8, src_b=4 with stage1 dest=4 -> fwd_a_sel=1, fwd_b_sel=2.
- Stall/flush: stage0 dest=10; assert stall 2 cycles -> stage0 still holds 10, two bubbles follow it to dest_out with regwrite_out=0. Then assert stall and flush together -> stage0 is a bubble and 10 enters stage1.
- Stats (macro defined): create 3 consecutive match cycles, then a reset pulse -> fwd_count reads 3, then 0 after reset.
